// File: rtl/obi_arb_pkg.sv
`default_nettype none
// ============================================================================
//  Module   : obi_arb_pkg
//  Purpose  : Shared types and constants for the OBI round-robin arbiter.
//             Holds the arbitration FSM state enum, the grant counter width
//             and a small wrap-around increment helper.
//  Revision : 1.0 - initial release
// ============================================================================
package obi_arb_pkg;

  // Arbiter FSM: IDLE arbitrates freely, LOCKED freezes the selection while
  // a request waits for its grant.
  typedef enum logic [0:0] {
    IDLE   = 1'b0,
    LOCKED = 1'b1
  } arb_state_e;

  // Width of each per-manager grant counter and its saturation value.
  localparam int unsigned               PERF_CNT_W   = 16;
  localparam logic [PERF_CNT_W-1:0]     PERF_CNT_MAX = '1;

  // (idx + 1) mod n without a divider; idx is always below n.
  function automatic int unsigned wrap_inc(int unsigned idx, int unsigned n);
    return ((idx + 1) >= n) ? 0 : (idx + 1);
  endfunction

endpackage
`default_nettype wire

// File: rtl/obi_arb_idx_fifo.sv
`default_nettype none
// ============================================================================
//  Module   : obi_arb_idx_fifo
//  Purpose  : Synchronous FIFO of granted manager indices, used to route
//             in-order responses back to their originator. Registered output
//             only: a pushed entry becomes visible on data_o one cycle later.
//  Ports    : clk, rst_n (async, active-high)
//             push_i/data_i  - write an entry (ignored when full)
//             pop_i/data_o   - remove the head entry (ignored when empty)
//             full_o, empty_o, count_o - occupancy status
//  Revision : 1.0 - initial release
// ============================================================================
module obi_arb_idx_fifo #(
  parameter int unsigned Depth = 8,   // power of two
  parameter int unsigned Width = 2
) (
  input  logic                         clk,
  input  logic                         rst_n,
  input  logic                         push_i,
  input  logic [Width-1:0]             data_i,
  input  logic                         pop_i,
  output logic [Width-1:0]             data_o,
  output logic                         full_o,
  output logic                         empty_o,
  output logic [$clog2(Depth+1)-1:0]   count_o
);

  localparam int unsigned PtrW = $clog2(Depth);
  localparam int unsigned CntW = $clog2(Depth+1);

  logic [Depth-1:0][Width-1:0] mem_q, mem_d;
  logic [PtrW-1:0]             wr_ptr_q, wr_ptr_d;
  logic [PtrW-1:0]             rd_ptr_q, rd_ptr_d;
  logic [CntW-1:0]             count_q, count_d;
  logic                        push_ok;
  logic                        pop_ok;

  assign full_o  = (count_q == CntW'(Depth));
  assign empty_o = (count_q == '0);
  assign count_o = count_q;
  assign data_o  = mem_q[rd_ptr_q];

  assign push_ok = push_i & ~full_o;
  assign pop_ok  = pop_i  & ~empty_o;

  // Depth is a power of two, so the pointers wrap on their own.
  always_comb begin
    mem_d    = mem_q;
    wr_ptr_d = wr_ptr_q;
    rd_ptr_d = rd_ptr_q;
    count_d  = count_q;
    if (push_ok) begin
      mem_d[wr_ptr_q] = data_i;
      wr_ptr_d        = wr_ptr_q + PtrW'(1);
    end
    if (pop_ok) begin
      rd_ptr_d = rd_ptr_q + PtrW'(1);
    end
    case ({push_ok, pop_ok})
      2'b10:   count_d = count_q + CntW'(1);
      2'b01:   count_d = count_q - CntW'(1);
      default: count_d = count_q;
    endcase
  end

  always_ff @(posedge clk or posedge rst_n) begin
    if (rst_n) begin
      mem_q    <= '0;
      wr_ptr_q <= '0;
      rd_ptr_q <= '0;
      count_q  <= '0;
    end else begin
      mem_q    <= mem_d;
      wr_ptr_q <= wr_ptr_d;
      rd_ptr_q <= rd_ptr_d;
      count_q  <= count_d;
    end
  end

endmodule
`default_nettype wire

// File: rtl/obi_rr_arbiter.sv
`default_nettype none
// ============================================================================
//  Module   : obi_rr_arbiter
//  Purpose  : Round-robin N:1 OBI arbiter. The A channel selects the first
//             requesting manager at or after the round-robin pointer and
//             freezes that choice while the request waits for its grant.
//             Granted indices are queued so responses return in order.
//  Ports    : clk, rst_n (async, active-high reset)
//             mgr_*  - NumMgr upstream manager ports (A + R channels)
//             sbr_*  - single downstream subordinate port
//             outstanding_o  - transactions granted but not yet responded
//             unexp_rsp_o    - sticky: response seen with nothing outstanding
//             perf_gnt_cnt_o - per-manager saturating grant counters
//  Config   : define OBI_ARB_PERF_CNT_EN to build the grant counters;
//             otherwise perf_gnt_cnt_o is tied to zero.
//  Revision : 1.0 - initial release
// ============================================================================
module obi_rr_arbiter
  import obi_arb_pkg::*;
#(
  parameter int unsigned NumMgr      = 4,
  parameter int unsigned NumMaxTrans = 8,
  parameter int unsigned AddrWidth   = 32,
  parameter int unsigned DataWidth   = 32
) (
  input  logic                                  clk,
  input  logic                                  rst_n,
  // Manager A channel
  input  logic [NumMgr-1:0]                     mgr_req_i,
  output logic [NumMgr-1:0]                     mgr_gnt_o,
  input  logic [NumMgr-1:0][AddrWidth-1:0]      mgr_addr_i,
  input  logic [NumMgr-1:0]                     mgr_we_i,
  input  logic [NumMgr-1:0][DataWidth/8-1:0]    mgr_be_i,
  input  logic [NumMgr-1:0][DataWidth-1:0]      mgr_wdata_i,
  // Manager R channel
  output logic [NumMgr-1:0]                     mgr_rvalid_o,
  input  logic [NumMgr-1:0]                     mgr_rready_i,
  output logic [DataWidth-1:0]                  mgr_rdata_o,
  output logic                                  mgr_err_o,
  // Subordinate A channel
  output logic                                  sbr_req_o,
  input  logic                                  sbr_gnt_i,
  output logic [AddrWidth-1:0]                  sbr_addr_o,
  output logic                                  sbr_we_o,
  output logic [DataWidth/8-1:0]                sbr_be_o,
  output logic [DataWidth-1:0]                  sbr_wdata_o,
  // Subordinate R channel
  input  logic                                  sbr_rvalid_i,
  output logic                                  sbr_rready_o,
  input  logic [DataWidth-1:0]                  sbr_rdata_i,
  input  logic                                  sbr_err_i,
  // Status
  output logic [$clog2(NumMaxTrans+1)-1:0]      outstanding_o,
  output logic                                  unexp_rsp_o,
  output logic [NumMgr-1:0][PERF_CNT_W-1:0]     perf_gnt_cnt_o
);

  localparam int unsigned IdxW = $clog2(NumMgr);

  arb_state_e      state_q, state_d;
  logic [IdxW-1:0] rr_ptr_q, rr_ptr_d;
  logic [IdxW-1:0] sel_q, sel_d;
  logic            unexp_q, unexp_d;

  logic [IdxW-1:0] rr_sel;
  logic [IdxW-1:0] sel;
  logic [IdxW-1:0] head_idx;
  logic            a_hs;
  logic            rsp_pop;
  logic            fifo_full;
  logic            fifo_empty;

  // --------------------------------------------------------------------------
  // Round-robin search. Walking the offsets from the far end down lets the
  // smallest offset from rr_ptr win. With no requester, rr_sel stays on
  // rr_ptr whose request bit is 0, so sbr_req_o falls out as 0 below.
  // --------------------------------------------------------------------------
  always_comb begin : rr_search
    logic [IdxW:0] cand;
    cand   = '0;
    rr_sel = rr_ptr_q;
    for (int i = NumMgr - 1; i >= 0; i--) begin
      cand = {1'b0, rr_ptr_q} + (IdxW+1)'(i);
      if (cand >= (IdxW+1)'(NumMgr)) begin
        cand = cand - (IdxW+1)'(NumMgr);
      end
      if (mgr_req_i[cand[IdxW-1:0]]) begin
        rr_sel = cand[IdxW-1:0];
      end
    end
  end

  // A waiting request keeps its slot even if a higher-priority manager
  // shows up meanwhile.
  assign sel = (state_q == LOCKED) ? sel_q : rr_sel;

  // Nothing is offered downstream while in reset or while the index FIFO
  // is full (a same-cycle pop does not free a slot until the next cycle).
  assign sbr_req_o   = ~rst_n & ~fifo_full & mgr_req_i[sel];
  assign sbr_addr_o  = mgr_addr_i[sel];
  assign sbr_we_o    = mgr_we_i[sel];
  assign sbr_be_o    = mgr_be_i[sel];
  assign sbr_wdata_o = mgr_wdata_i[sel];

  assign a_hs = sbr_req_o & sbr_gnt_i;

  always_comb begin
    mgr_gnt_o      = '0;
    mgr_gnt_o[sel] = a_hs;
  end

  // --------------------------------------------------------------------------
  // Selection FSM and round-robin pointer
  // --------------------------------------------------------------------------
  always_comb begin
    state_d  = state_q;
    sel_d    = sel_q;
    rr_ptr_d = rr_ptr_q;
    unique case (state_q)
      IDLE: begin
        if (sbr_req_o && !sbr_gnt_i) begin
          state_d = LOCKED;
          sel_d   = rr_sel;
        end
      end
      LOCKED: begin
        if (sbr_gnt_i) begin
          state_d = IDLE;
        end
      end
      default: state_d = IDLE;
    endcase
    if (a_hs) begin
      rr_ptr_d = IdxW'(wrap_inc(32'(sel), NumMgr));
    end
  end

  // --------------------------------------------------------------------------
  // In-order response routing. With nothing outstanding the response is
  // accepted and dropped so the subordinate cannot stall.
  // --------------------------------------------------------------------------
  assign sbr_rready_o = fifo_empty ? 1'b1 : mgr_rready_i[head_idx];
  assign rsp_pop      = sbr_rvalid_i & sbr_rready_o & ~fifo_empty;
  assign mgr_rdata_o  = sbr_rdata_i;
  assign mgr_err_o    = sbr_err_i;

  always_comb begin
    mgr_rvalid_o = '0;
    if (!fifo_empty) begin
      mgr_rvalid_o[head_idx] = sbr_rvalid_i;
    end
  end

  assign unexp_d     = unexp_q | (sbr_rvalid_i & fifo_empty);
  assign unexp_rsp_o = unexp_q;

  obi_arb_idx_fifo #(
    .Depth (NumMaxTrans),
    .Width (IdxW)
  ) u_idx_fifo (
    .clk     (clk),
    .rst_n   (rst_n),
    .push_i  (a_hs),
    .data_i  (sel),
    .pop_i   (rsp_pop),
    .data_o  (head_idx),
    .full_o  (fifo_full),
    .empty_o (fifo_empty),
    .count_o (outstanding_o)
  );

  always_ff @(posedge clk or posedge rst_n) begin
    if (rst_n) begin
      state_q  <= IDLE;
      rr_ptr_q <= '0;
      sel_q    <= '0;
      unexp_q  <= 1'b0;
    end else begin
      state_q  <= state_d;
      rr_ptr_q <= rr_ptr_d;
      sel_q    <= sel_d;
      unexp_q  <= unexp_d;
    end
  end

  // --------------------------------------------------------------------------
  // Per-manager saturating grant counters
  // --------------------------------------------------------------------------
`ifdef OBI_ARB_PERF_CNT_EN
  for (genvar m = 0; m < NumMgr; m++) begin : g_perf_cnt
    logic [PERF_CNT_W-1:0] cnt_q, cnt_d;

    always_comb begin
      cnt_d = cnt_q;
      if (mgr_gnt_o[m] && (cnt_q != PERF_CNT_MAX)) begin
        cnt_d = cnt_q + PERF_CNT_W'(1);
      end
    end

    always_ff @(posedge clk or posedge rst_n) begin
      if (rst_n) begin
        cnt_q <= '0;
      end else begin
        cnt_q <= cnt_d;
      end
    end

    assign perf_gnt_cnt_o[m] = cnt_q;
  end
`else
  assign perf_gnt_cnt_o = '0;
`endif

endmodule
`default_nettype wire

// File: doc/obi_rr_arbiter.md
OBI_RR_ARBITER -- requirements
Module: obi_rr_arbiter

Interface
REQ-001 The block SHALL have parameter NumMgr, default 4, giving the number of upstream manager ports (2..16).
REQ-002 The block SHALL have parameter NumMaxTrans, default 8, giving the maximum outstanding transactions (power of two, 2..32).
REQ-003 The block SHALL have parameters AddrWidth, default 32, and DataWidth, default 32, giving the address and data widths.
REQ-004 clk  in  1  clock; all state changes on the rising edge.
REQ-005 rst_n  in  1  reset, asynchronous, active-high.
REQ-006 mgr_req_i / mgr_gnt_o  in/out  NumMgr  per-manager A-channel request and grant.
REQ-007 mgr_addr_i, mgr_we_i, mgr_be_i, mgr_wdata_i  in  NumMgr x (AddrWidth, 1, DataWidth/8, DataWidth)  per-manager A payload.
REQ-008 mgr_rvalid_o / mgr_rready_i  out/in  NumMgr  per-manager R handshake.
REQ-009 mgr_rdata_o, mgr_err_o  out  DataWidth, 1  R payload shared by all managers; qualified only by mgr_rvalid_o.
REQ-010 sbr_req_o, sbr_gnt_i, sbr_addr_o, sbr_we_o, sbr_be_o, sbr_wdata_o  out/in  mirrored widths  downstream A channel.
REQ-011 sbr_rvalid_i, sbr_rready_o, sbr_rdata_i, sbr_err_i  in/out  mirrored widths  downstream R channel.
REQ-012 outstanding_o  out  $clog2(NumMaxTrans+1)  count of granted transactions with no R handshake yet.
REQ-013 unexp_rsp_o  out  1  sticky flag: response received while no transaction was outstanding.
REQ-014 perf_gnt_cnt_o  out  NumMgr x 16  per-manager grant counters.

Function
REQ-015 Arbitration SHALL be round-robin: the selected manager is the first requesting index at or after rr_ptr, wrapping modulo NumMgr.
REQ-016 The FSM SHALL have states IDLE and LOCKED: IDLE->LOCKED when sbr_req_o=1 and sbr_gnt_i=0; LOCKED->IDLE on sbr_gnt_i=1.
REQ-017 In LOCKED the selection SHALL be frozen and SHALL NOT change, even if another manager with higher round-robin priority raises a request.
REQ-018 sbr_req_o and the sbr A payload SHALL equal those of the selected manager; mgr_gnt_o[sel] SHALL equal sbr_gnt_i combinationally (zero-cycle latency); all other grant bits SHALL be 0.
REQ-019 On an A handshake, rr_ptr SHALL become (sel+1) mod NumMgr and sel SHALL be pushed into the index FIFO.
REQ-020 When the FIFO is full, sbr_req_o SHALL be 0 and all mgr_gnt_o SHALL be 0, even if a pop occurs in the same cycle.
REQ-021 Responses SHALL be returned in order: mgr_rvalid_o[head] = sbr_rvalid_i, sbr_rready_o = mgr_rready_i[head], and the FIFO SHALL pop on sbr_rvalid_i && sbr_rready_o.
REQ-022 A simultaneous push and pop SHALL leave outstanding_o unchanged; the count SHALL never wrap.
REQ-023 sbr_rvalid_i=1 with an empty FIFO SHALL set unexp_rsp_o, SHALL route the response to no manager, and SHALL drive sbr_rready_o=1 so the response is consumed.
REQ-024 A manager that is not requesting SHALL NOT be granted; if no manager requests, sbr_req_o SHALL be 0.

Reset
REQ-025 While rst_n=1: FSM in IDLE, rr_ptr=0, FIFO empty, outstanding_o=0, unexp_rsp_o=0, perf counters=0, all gnt and rvalid outputs 0.
REQ-026 Reset asserted mid-transaction SHALL discard all outstanding entries; responses arriving after reset release SHALL be treated per REQ-023.

Configuration
REQ-027 With OBI_ARB_PERF_CNT_EN defined, each perf_gnt_cnt_o entry SHALL increment on its manager's A handshake and saturate at 16'hFFFF.
REQ-028 Without OBI_ARB_PERF_CNT_EN, perf_gnt_cnt_o SHALL be tied to 0 and no counter flops SHALL exist.

Structure
REQ-029 Package obi_arb_pkg SHALL hold the arb_state_e enum (IDLE, LOCKED) and the 16-bit perf counter width constant.
REQ-030 The index FIFO SHALL be the sub-module obi_arb_idx_fifo (depth NumMaxTrans, width $clog2(NumMgr), no fall-through).

Verification
REQ-031 Managers 0 and 2 request continuously, sbr_gnt_i=1 -> grants alternate 0,2,0,2 and rr_ptr wraps correctly.
REQ-032 Manager 1 requests with sbr_gnt_i=0 for 5 cycles while manager 0 raises a request -> selection stays 1 until the grant, then moves to manager 0.
REQ-033 NumMaxTrans=8 with sbr_rvalid_i held at 0 -> exactly 8 grants, then sbr_req_o=0 and outstanding_o=8; one response -> outstanding_o=7 and the next grant is issued in the following cycle.
REQ-034 Grants issued to managers 3,1,2 with responses rdata A,B,C -> mgr_rvalid_o pulses at 3,1,2 carrying A,B,C respectively; mgr_rready_i[1]=0 stalls sbr_rready_o.
REQ-035 sbr_rvalid_i=1 with no outstanding transactions -> unexp_rsp_o=1 and remains set until reset.
REQ-036 With OBI_ARB_PERF_CNT_EN, 70000 grants to manager 0 -> perf_gnt_cnt_o[0]=16'hFFFF; without the macro, the same stimulus leaves the counter at 0.
